// File: rtl/wb_trace_tx.sv
// wb_trace_tx - writeback-trace transmitter.
//
// Snoops register-file writes at writeback, buffers them in a small FIFO and
// serialises each one as a 5-byte frame on an 8-bit valid/ready stream:
//   B0 = {3'b101, rd_addr}, B1..B4 = rd_writedata, most significant byte first.
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   enable            capture enable; the FIFO keeps draining while low
//   regfile_we        writeback register-file write enable
//   rd_addr           destination register (writes to $0 are never captured)
//   rd_writedata      data written
//   clr_stats         one-cycle pulse clearing overflow / drop_count
//   tx_data/tx_valid  outbound byte stream, accepted when tx_ready is high
//   tx_ready          sink ready
//   fifo_empty        FIFO holds no events (the frame register is not counted)
//   overflow          sticky flag: at least one event was dropped
//   drop_count        saturating count of dropped events
module wb_trace_tx #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  regfile_we,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_writedata,
    input  logic                  clr_stats,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  fifo_empty,
    output logic                  overflow,
    output logic [15:0]           drop_count
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned REC_W = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_e;

    // FIFO storage and bookkeeping
    logic [REC_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    // Serializer
    state_e               state_q, state_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_WIDTH-1:0] frame_data_q, frame_data_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_valid_q, tx_valid_d;

    // Statistics
    logic                 overflow_q, overflow_d;
    logic [15:0]          drop_count_q, drop_count_d;

    // Per-cycle control
    logic                 capture;
    logic                 push;
    logic                 pop;
    logic                 drop;
    logic                 handshake;
    logic [REC_W-1:0]     head;
    logic [15:0]          drop_base;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        frame_data_d = frame_data_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        drop_base    = drop_count_q;
        pop          = 1'b0;
        head         = mem_q[rd_ptr_q];
        handshake    = tx_valid_q && tx_ready;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop = 1'b1;
                end
            end
            S_SEND: begin
                if (handshake) begin
                    if (idx_q != 3'd4) begin
                        // Preload the byte after the one just accepted so
                        // tx_data is a plain register output.
                        idx_d = idx_q + 3'd1;
                        case (idx_q)
                            3'd0:    tx_data_d = frame_data_q[31:24];
                            3'd1:    tx_data_d = frame_data_q[23:16];
                            3'd2:    tx_data_d = frame_data_q[15:8];
                            default: tx_data_d = frame_data_q[7:0];
                        endcase
                    end else if (count_q != '0) begin
                        pop = 1'b1;
                    end else begin
                        state_d    = S_IDLE;
                        tx_valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d    = S_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase

        // Loading a new frame is shared by IDLE start-up and back-to-back send.
        if (pop) begin
            state_d      = S_SEND;
            idx_d        = 3'd0;
            tx_valid_d   = 1'b1;
            frame_data_d = head[DATA_WIDTH-1:0];
            tx_data_d    = {3'b101, head[REC_W-1 -: ADDR_WIDTH]};
            rd_ptr_d     = rd_ptr_q + 1'b1;
        end

        // A full FIFO can still accept when a pop frees a slot this cycle.
        capture = enable && regfile_we && (rd_addr != '0);
        push    = capture && ((count_q != DEPTH_C) || pop);
        drop    = capture && !push;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Clear first, then account for a drop in the same cycle.
        if (clr_stats) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
            drop_base    = '0;
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_base != 16'hFFFF) begin
                drop_count_d = drop_base + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            frame_data_q <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            frame_data_q <= frame_data_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Storage needs no reset: validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {rd_addr, rd_writedata};
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign fifo_empty = (count_q == '0);
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_wb_trace_tx.sv
module tb_wb_trace_tx;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        regfile_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_writedata;
    logic        clr_stats;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        fifo_empty;
    logic        overflow;
    logic [15:0] drop_count;

    wb_trace_tx #(
        .FIFO_DEPTH(DEPTH),
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .regfile_we  (regfile_we),
        .rd_addr     (rd_addr),
        .rd_writedata(rd_writedata),
        .clr_stats   (clr_stats),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .fifo_empty  (fifo_empty),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of pending events, plus the bytes of the frame
    // currently on the wire (empty queue = nothing presented).
    logic [36:0] m_q[$];
    logic [7:0]  m_cur[$];
    bit          m_ovf;
    int unsigned m_drops;

    task automatic model_reset();
        m_q.delete();
        m_cur.delete();
        m_ovf = 0;
        m_drops = 0;
    endtask

    task automatic model_edge();
        bit cap, pop, accept;
        logic [36:0] ev;
        cap = enable && regfile_we && (rd_addr != 5'd0);
        if (m_cur.size() > 0 && tx_ready) void'(m_cur.pop_front());
        pop = (m_cur.size() == 0) && (m_q.size() > 0);
        accept = cap && ((m_q.size() < DEPTH) || pop);
        if (pop) begin
            ev = m_q.pop_front();
            m_cur.push_back({3'b101, ev[36:32]});
            m_cur.push_back(ev[31:24]);
            m_cur.push_back(ev[23:16]);
            m_cur.push_back(ev[15:8]);
            m_cur.push_back(ev[7:0]);
        end
        if (clr_stats) begin
            m_ovf = 0;
            m_drops = 0;
        end
        if (cap && !accept) begin
            m_ovf = 1;
            if (m_drops < 65535) m_drops++;
        end
        if (accept) m_q.push_back({rd_addr, rd_writedata});
    endtask

    task automatic compare_model();
        chk("tx_valid", 40'(tx_valid), 40'(m_cur.size() > 0));
        if (m_cur.size() > 0) chk("tx_data", 40'(tx_data), 40'(m_cur[0]));
        chk("fifo_empty", 40'(fifo_empty), 40'(m_q.size() == 0));
        chk("overflow", 40'(overflow), 40'(m_ovf));
        chk("drop_count", 40'(drop_count), 40'(m_drops));
    endtask

    // One clock: model follows the edge, DUT is compared on the falling edge.
    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        else model_reset();
        @(negedge clk);
        compare_model();
    endtask

    task automatic set_cap(input logic en, input logic [4:0] a, input logic [31:0] d);
        enable = en;
        regfile_we = 1'b1;
        rd_addr = a;
        rd_writedata = d;
    endtask

    task automatic idle_inputs();
        regfile_we = 1'b0;
        clr_stats = 1'b0;
        enable = 1'b1;
    endtask

    // Drain nbytes with tx_ready high, packing them MSB-first into got.
    task automatic collect(input int nbytes, output logic [39:0] got);
        int n;
        n = 0;
        got = '0;
        idle_inputs();
        tx_ready = 1'b1;
        for (int c = 0; c < 60 && n < nbytes; c++) begin
            if (tx_valid) begin
                got = {got[31:0], tx_data};
                n++;
            end
            step();
        end
        chk("collect_count", 40'(n), 40'(nbytes));
    endtask

    typedef struct {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
        bit          expect_frame;
        logic [39:0] frame;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [39:0] got;
        int vcnt;

        vecs[0] = '{1'b1, 5'd31, 32'h0000_0003, 1'b1, 40'hBF_00_00_00_03};
        vecs[1] = '{1'b1, 5'd0,  32'h1234_5678, 1'b0, 40'h0};
        vecs[2] = '{1'b0, 5'd7,  32'h0000_0055, 1'b0, 40'h0};
        vecs[3] = '{1'b1, 5'd28, 32'hFFFF_FFF0, 1'b1, 40'hBC_FF_FF_FF_F0};
        vecs[4] = '{1'b1, 5'd1,  32'hDEAD_BEEF, 1'b1, 40'hA1_DE_AD_BE_EF};
        vecs[5] = '{1'b1, 5'd22, 32'h0000_0007, 1'b1, 40'hB6_00_00_00_07};
        vecs[6] = '{1'b1, 5'd16, 32'h8000_0001, 1'b1, 40'hB0_80_00_00_01};

        rst_n = 1'b0;
        enable = 1'b1;
        regfile_we = 1'b0;
        rd_addr = '0;
        rd_writedata = '0;
        clr_stats = 1'b0;
        tx_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_tx_valid", 40'(tx_valid), 40'd0);
        chk("rst_tx_data", 40'(tx_data), 40'h00);
        chk("rst_fifo_empty", 40'(fifo_empty), 40'd1);
        chk("rst_overflow", 40'(overflow), 40'd0);
        chk("rst_drop_count", 40'(drop_count), 40'd0);
        rst_n = 1'b1;
        step();

        // Table: single events, including non-captured cases.
        foreach (vecs[i]) begin
            tx_ready = 1'b1;
            set_cap(vecs[i].en, vecs[i].addr, vecs[i].data);
            step();
            idle_inputs();
            chk("vec_valid_after_capture", 40'(tx_valid), 40'd0);
            if (vecs[i].expect_frame) begin
                chk("vec_fifo_loaded", 40'(fifo_empty), 40'd0);
                step();
                chk("vec_valid_after_pop", 40'(tx_valid), 40'd1);
                collect(5, got);
                chk("vec_frame", got, vecs[i].frame);
                chk("vec_idle_after", 40'(tx_valid), 40'd0);
            end else begin
                vcnt = 0;
                for (int c = 0; c < 6; c++) begin
                    if (tx_valid || !fifo_empty) vcnt++;
                    step();
                end
                chk("vec_no_capture", 40'(vcnt), 40'd0);
            end
        end

        // Backpressure: stall 5 cycles while B2 is presented.
        tx_ready = 1'b1;
        set_cap(1'b1, 5'd30, 32'h0000_0007);
        step();
        idle_inputs();
        step();
        chk("bp_b0", 40'(tx_data), 40'hBE);
        step();
        chk("bp_b1", 40'(tx_data), 40'h00);
        step();
        tx_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp_hold_valid", 40'(tx_valid), 40'd1);
            chk("bp_hold_data", 40'(tx_data), 40'h00);
        end
        collect(3, got);
        chk("bp_tail", got, 40'h00_00_07);

        // Overflow: 10 captures with the sink stalled -> 9 retained, 1 dropped.
        tx_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            set_cap(1'b1, 5'(k), 32'(k * 32'h1111));
            step();
        end
        idle_inputs();
        chk("ovf_drop_count", 40'(drop_count), 40'd1);
        chk("ovf_flag", 40'(overflow), 40'd1);
        chk("ovf_fifo_nonempty", 40'(fifo_empty), 40'd0);
        // Clear coinciding with a drop.
        set_cap(1'b1, 5'd11, 32'hCAFE_0011);
        clr_stats = 1'b1;
        step();
        idle_inputs();
        chk("clr_drop_count", 40'(drop_count), 40'd1);
        chk("clr_drop_flag", 40'(overflow), 40'd1);
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        chk("clr_count_zero", 40'(drop_count), 40'd0);
        chk("clr_flag_zero", 40'(overflow), 40'd0);
        for (int k = 1; k <= 9; k++) begin
            collect(5, got);
            chk("ovf_frame", got, {3'b101, 5'(k), 32'(k * 32'h1111)});
        end
        chk("ovf_drained", 40'(fifo_empty), 40'd1);

        // Reset in the middle of a frame with 3 events queued.
        tx_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_cap(1'b1, 5'(20 + k), 32'hAB00_0000 + 32'(k));
            step();
        end
        idle_inputs();
        tx_ready = 1'b1;
        step();
        step();
        chk("rstmid_b2_shown", 40'(tx_data), 40'h00);
        rst_n = 1'b0;
        #1;
        chk("rstmid_tx_valid", 40'(tx_valid), 40'd0);
        chk("rstmid_tx_data", 40'(tx_data), 40'h00);
        chk("rstmid_fifo_empty", 40'(fifo_empty), 40'd1);
        model_reset();
        step();
        rst_n = 1'b1;
        set_cap(1'b1, 5'd5, 32'h0000_00A5);
        step();
        idle_inputs();
        collect(5, got);
        chk("rstmid_new_frame", got, 40'hA5_00_00_00_A5);

        // Randomised traffic against the model, with bursty sink stalls.
        for (int c = 0; c < 3000; c++) begin
            if ((c % 64) < 24) tx_ready = ($urandom_range(0, 7) == 0);
            else tx_ready = ($urandom_range(0, 3) != 0);
            enable = ($urandom_range(0, 9) != 0);
            regfile_we = ($urandom_range(0, 2) != 0);
            rd_addr = 5'($urandom_range(0, 31));
            rd_writedata = $urandom;
            clr_stats = ($urandom_range(0, 59) == 0);
            step();
        end
        idle_inputs();
        tx_ready = 1'b1;
        for (int c = 0; c < 60; c++) step();
        chk("final_empty", 40'(fifo_empty), 40'd1);
        chk("final_idle", 40'(tx_valid), 40'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
